mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
// Multicycle MIPS control FSM; drives alu_ctl and datapath selects into the ALU, the opposite end of the ALU control interface.
// Decodes the instruction-register word and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Handshakes with a wait-state memory and uses the ALU condition flag (zero/nonzero) to resolve beq/bne.
// PARAMETERS
// WAIT_MAX  15  max cycles waiting on mem_ready in one memory state before bus_err (4-bit counter)
// PORTS
// clk          in   1   clock, rising edge
// rst_n        in   1   asynchronous active-low reset
// instr        in   32  instruction register contents (valid from DECODE onward)
// alu_cond     in   1   ALU flag: 1 = (result==0 for alu_ctl[3]=0) or (result!=0 for alu_ctl[3]=1)
// mem_ready    in   1   memory access complete this cycle
// alu_ctl      out  4   0010 add,0011 addu,0110 sub/beq,1110 bne,0000 and,0001 or,1011 xor,0111 slt,1001 sll,1010 srl,1000 passB
// alu_src_a    out  1   0=PC, 1=regA
// alu_src_b    out  3   000 regB,001 const4,010 sext imm,011 sext imm<<2,100 zext imm,101 imm<<16
// mem_read     out  1   memory read request
// mem_write    out  1   memory write request
// i_or_d       out  1   0=address from PC, 1=from ALUOut register
// ir_write     out  1   load instruction register
// pc_write     out  1   load PC
// pc_source    out  2   00 ALU result, 01 ALUOut reg (branch target), 10 jump target {PC[31:28],instr[25:0],2'b00}
// reg_write    out  1   register-file write enable
// reg_dst      out  1   0=rt, 1=rd
// mem_to_reg   out  1   0=ALUOut, 1=memory data register
// illegal      out  1   one-cycle pulse: unsupported opcode/funct
// bus_err      out  1   one-cycle pulse: memory timeout
// BEHAVIOUR
// - rst_n=0: state=BOOT, wait_cnt=0; every output 0. BOOT -> FETCH on first clk edge after release.
// - Outputs are Moore (decoded from state), except pc_write/ir_write in FETCH (gated by mem_ready), pc_write in BRANCH (=alu_cond).
// - FETCH: mem_read=1,i_or_d=0,alu_src_a=0,alu_src_b=001,alu_ctl=0010,pc_source=00; mem_ready=1 -> ir_write=1,pc_write=1, go DECODE.
// - DECODE: alu_src_a=0,alu_src_b=011,alu_ctl=0010 (branch target to ALUOut). Next by opcode:
//   R-type(000000): funct 20 add,21 addu,22 sub,24 and,25 or,26 xor,2A slt,00 sll,02 srl -> EXEC_R; else illegal.
//   08 addi,09 addiu,0A slti,0C andi,0D ori,0E xori,0F lui -> EXEC_I; 23 lw,2B sw -> MEM_ADDR;
//   04 beq,05 bne -> BRANCH; 02 j -> JUMP; other opcode -> illegal=1, next FETCH.
// - EXEC_R: alu_src_a=1,alu_src_b=000,alu_ctl from funct -> ALU_WB(reg_dst=1).
// - EXEC_I: alu_src_a=1; addi/addiu/slti src_b=010; andi/ori/xori src_b=100; lui src_b=101,alu_ctl=1000 -> ALU_WB(reg_dst=0).
// - ALU_WB: reg_write=1,mem_to_reg=0 -> FETCH. reg_dst held from instr type.
// - MEM_ADDR: alu_src_a=1,alu_src_b=010,alu_ctl=0010 -> MEM_RD (lw) or MEM_WR (sw).
// - MEM_RD: mem_read=1,i_or_d=1; mem_ready -> MEM_WB. MEM_WB: reg_write=1,mem_to_reg=1,reg_dst=0 -> FETCH.
// - MEM_WR: mem_write=1,i_or_d=1; mem_ready -> FETCH.
// - BRANCH: alu_src_a=1,alu_src_b=000,alu_ctl=0110(beq)/1110(bne),pc_source=01,pc_write=alu_cond -> FETCH.
// - JUMP: pc_source=10,pc_write=1 -> FETCH.
// - Latency at zero wait states: R/I-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3.
// - wait_cnt clears on entry to FETCH/MEM_RD/MEM_WR, increments each cycle mem_ready=0, saturates (no wrap).
//   If wait_cnt==WAIT_MAX and mem_ready=0: bus_err=1 one cycle, no ir_write/pc_write/reg_write, next FETCH (retries same PC).
//   mem_ready=1 on the same cycle as the timeout: completion wins, no bus_err.
// - mem_ready ignored outside FETCH/MEM_RD/MEM_WR. Async reset mid-instruction aborts immediately; no partial writes after.
// TESTING
// - Reset: rst_n low 3 cycles -> all outputs 0; release -> BOOT 1 cycle, then mem_read=1,alu_ctl=0010.
// - add 0x00221820, mem_ready=1: cycle4 alu_ctl held 0010 in EXEC_R, then ALU_WB reg_write=1,reg_dst=1; sub 0x00221822 -> 0110.
// - beq 0x10220003 alu_cond=1 -> BRANCH alu_ctl=0110,pc_source=01,pc_write=1; alu_cond=0 -> pc_write=0; bne 0x14220003 -> alu_ctl=1110.
// - lw 0x8C220004, mem_ready=0 for 3 cycles in MEM_RD -> mem_read=1,i_or_d=1 held; then MEM_WB reg_write=1,mem_to_reg=1.
// - mem_ready=0 in FETCH for WAIT_MAX+1 cycles -> single bus_err pulse, pc_write never 1, FETCH re-entered with wait_cnt=0.
// - lui 0x3C011234 -> alu_ctl=1000,alu_src_b=101; sll 0x00021080 -> 1001; opcode 0x3F -> illegal pulse, next FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle
// controller (master) and the wait-state memory (slave).
interface mips_multicycle_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: decodes the IR word and
// sequences fetch/decode/execute/memory/writeback.
module mips_multicycle_ctrl #(
  parameter logic [3:0] WAIT_MAX = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  mips_multicycle_ctrl_if.master mem,
  input  logic [31:0] instr,
  input  logic        alu_cond,
  output logic [3:0]  alu_ctl,
  output logic        alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [3:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
  } state_t;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctl_t;

  state_t     state;
  state_t     nxt;
  ctl_t       ctl_q;
  ctl_t       ctl_nxt;
  logic [3:0] wait_cnt;
  logic       mem_st;
  logic       timeout;
  logic       bad;

  logic [5:0] op;
  logic [5:0] fn;
  logic       r_ok;
  logic [3:0] r_ctl;
  logic       i_ok;
  logic [3:0] i_ctl;
  logic [2:0] i_srcb;
  logic       r_sel;
  logic       ls_sel;
  logic       br_sel;
  logic       j_sel;
  logic       unused_instr;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_instr = ^instr[25:6];

  assign r_sel  = (op == 6'h00) && r_ok;
  assign ls_sel = (op == 6'h23) || (op == 6'h2B);
  assign br_sel = (op == 6'h04) || (op == 6'h05);
  assign j_sel  = (op == 6'h02);

  // R-type funct to ALU operation
  always_comb begin
    r_ok  = 1'b1;
    r_ctl = 4'b0000;
    case (fn)
      6'h20:   r_ctl = 4'b0010;
      6'h21:   r_ctl = 4'b0011;
      6'h22:   r_ctl = 4'b0110;
      6'h24:   r_ctl = 4'b0000;
      6'h25:   r_ctl = 4'b0001;
      6'h26:   r_ctl = 4'b1011;
      6'h2A:   r_ctl = 4'b0111;
      6'h00:   r_ctl = 4'b1001;
      6'h02:   r_ctl = 4'b1010;
      default: r_ok  = 1'b0;
    endcase
  end

  // I-type opcode to ALU operation and immediate form
  always_comb begin
    i_ok   = 1'b1;
    i_ctl  = 4'b0000;
    i_srcb = 3'b010;
    case (op)
      6'h08: i_ctl = 4'b0010;
      6'h09: i_ctl = 4'b0011;
      6'h0A: i_ctl = 4'b0111;
      6'h0C: begin
        i_ctl  = 4'b0000;
        i_srcb = 3'b100;
      end
      6'h0D: begin
        i_ctl  = 4'b0001;
        i_srcb = 3'b100;
      end
      6'h0E: begin
        i_ctl  = 4'b1011;
        i_srcb = 3'b100;
      end
      6'h0F: begin
        i_ctl  = 4'b1000;
        i_srcb = 3'b101;
      end
      default: i_ok = 1'b0;
    endcase
  end

  // next state, timeout and illegal detection
  always_comb begin
    nxt     = state;
    bad     = 1'b0;
    mem_st  = (state == S_FETCH) ||
              (state == S_MEM_RD) ||
              (state == S_MEM_WR);
    timeout = mem_st && !mem.mem_ready &&
              (wait_cnt == WAIT_MAX);
    case (state)
      S_BOOT: nxt = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ready) nxt = S_DECODE;
        else if (timeout)  nxt = S_FETCH;
      end
      S_DECODE: begin
        unique case (1'b1)
          r_sel:  nxt = S_EXEC_R;
          i_ok:   nxt = S_EXEC_I;
          ls_sel: nxt = S_MEM_ADDR;
          br_sel: nxt = S_BRANCH;
          j_sel:  nxt = S_JUMP;
          default: begin
            nxt = S_FETCH;
            bad = 1'b1;
          end
        endcase
      end
      S_EXEC_R: nxt = S_ALU_WB;
      S_EXEC_I: nxt = S_ALU_WB;
      S_ALU_WB: nxt = S_FETCH;
      S_MEM_ADDR: begin
        nxt = (op == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem.mem_ready) nxt = S_MEM_WB;
        else if (timeout)  nxt = S_FETCH;
      end
      S_MEM_WB: nxt = S_FETCH;
      S_MEM_WR: begin
        if (mem.mem_ready || timeout) nxt = S_FETCH;
      end
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // Moore outputs of the state being entered
  always_comb begin
    ctl_nxt = '0;
    case (nxt)
      S_FETCH: begin
        ctl_nxt.mem_read  = 1'b1;
        ctl_nxt.alu_src_b = 3'b001;
        ctl_nxt.alu_ctl   = 4'b0010;
      end
      S_DECODE: begin
        ctl_nxt.alu_src_b = 3'b011;
        ctl_nxt.alu_ctl   = 4'b0010;
      end
      S_EXEC_R: begin
        ctl_nxt.alu_src_a = 1'b1;
        ctl_nxt.alu_ctl   = r_ctl;
      end
      S_EXEC_I: begin
        ctl_nxt.alu_src_a = 1'b1;
        ctl_nxt.alu_src_b = i_srcb;
        ctl_nxt.alu_ctl   = i_ctl;
      end
      S_ALU_WB: begin
        ctl_nxt.reg_write = 1'b1;
        ctl_nxt.reg_dst   = (state == S_EXEC_R);
      end
      S_MEM_ADDR: begin
        ctl_nxt.alu_src_a = 1'b1;
        ctl_nxt.alu_src_b = 3'b010;
        ctl_nxt.alu_ctl   = 4'b0010;
      end
      S_MEM_RD: begin
        ctl_nxt.mem_read = 1'b1;
        ctl_nxt.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctl_nxt.reg_write  = 1'b1;
        ctl_nxt.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctl_nxt.mem_write = 1'b1;
        ctl_nxt.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        ctl_nxt.alu_src_a = 1'b1;
        ctl_nxt.pc_source = 2'b01;
        ctl_nxt.alu_ctl   = (op == 6'h05) ?
                            4'b1110 : 4'b0110;
      end
      S_JUMP: ctl_nxt.pc_source = 2'b10;
      default: ctl_nxt = '0;
    endcase
  end

  // state, wait counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      wait_cnt <= '0;
      ctl_q    <= '0;
    end else begin
      state <= nxt;
      ctl_q <= ctl_nxt;
      if ((nxt != state) || timeout)
        wait_cnt <= '0;
      else if (mem_st && !mem.mem_ready &&
               (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign alu_ctl       = ctl_q.alu_ctl;
  assign alu_src_a     = ctl_q.alu_src_a;
  assign alu_src_b     = ctl_q.alu_src_b;
  assign mem.mem_read  = ctl_q.mem_read;
  assign mem.mem_write = ctl_q.mem_write;
  assign mem.i_or_d    = ctl_q.i_or_d;
  assign pc_source     = ctl_q.pc_source;
  assign reg_write     = ctl_q.reg_write;
  assign reg_dst       = ctl_q.reg_dst;
  assign mem_to_reg    = ctl_q.mem_to_reg;

  assign ir_write = (state == S_FETCH) && mem.mem_ready;
  assign pc_write = ((state == S_FETCH) && mem.mem_ready) ||
                    ((state == S_BRANCH) && alu_cond) ||
                    (state == S_JUMP);
  assign illegal  = (state == S_DECODE) && bad;
  assign bus_err  = timeout;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-instruction
// cycle expectations from a behavioural model.
module tb_mips_multicycle_ctrl;
  localparam int WMAX = 15;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3;
  localparam int K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       bus_err;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        cond;
    logic [31:0] ins;
  } in_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_cond = 1'b0;
  logic        rdy_d = 1'b0;
  logic [3:0]  alu_ctl;
  logic        alu_src_a;
  logic [2:0]  alu_src_b;
  logic        ir_write, pc_write;
  logic [1:0]  pc_source;
  logic        reg_write, reg_dst, mem_to_reg;
  logic        illegal, bus_err;

  in_t  drv_q[$];
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mips_multicycle_ctrl_if bus();
  assign bus.mem_ready = rdy_d;

  mips_multicycle_ctrl #(.WAIT_MAX(4'd15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus),
    .instr      (instr),
    .alu_cond   (alu_cond),
    .alu_ctl    (alu_ctl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  out_t act;
  assign act = {alu_ctl, alu_src_a, alu_src_b,
                bus.mem_read, bus.mem_write, bus.i_or_d,
                ir_write, pc_write, pc_source,
                reg_write, reg_dst, mem_to_reg,
                illegal, bus_err};

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void put(bit rst, logic [31:0] ins,
                              bit rdy, bit cond, out_t o);
    in_t d;
    d.rst  = rst;
    d.rdy  = rdy;
    d.cond = cond;
    d.ins  = ins;
    drv_q.push_back(d);
    exp_q.push_back(o);
  endfunction

  // n cycles held in reset, then one BOOT cycle
  function automatic void push_reset(int n);
    for (int i = 0; i < n; i++)
      put(1'b1, $urandom, rb(), rb(), '0);
    put(1'b0, $urandom, rb(), rb(), '0);
  endfunction

  function automatic void classify(input logic [31:0] ins,
                                   output int k,
                                   output logic [3:0] ctl,
                                   output logic [2:0] sb);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    k = K_ILL;
    ctl = 4'b0000;
    sb = 3'b000;
    case (op)
      6'h00: begin
        k = K_R;
        case (fn)
          6'h20: ctl = 4'b0010;
          6'h21: ctl = 4'b0011;
          6'h22: ctl = 4'b0110;
          6'h24: ctl = 4'b0000;
          6'h25: ctl = 4'b0001;
          6'h26: ctl = 4'b1011;
          6'h2A: ctl = 4'b0111;
          6'h00: ctl = 4'b1001;
          6'h02: ctl = 4'b1010;
          default: k = K_ILL;
        endcase
      end
      6'h08: begin k = K_I; ctl = 4'b0010; sb = 3'b010; end
      6'h09: begin k = K_I; ctl = 4'b0011; sb = 3'b010; end
      6'h0A: begin k = K_I; ctl = 4'b0111; sb = 3'b010; end
      6'h0C: begin k = K_I; ctl = 4'b0000; sb = 3'b100; end
      6'h0D: begin k = K_I; ctl = 4'b0001; sb = 3'b100; end
      6'h0E: begin k = K_I; ctl = 4'b1011; sb = 3'b100; end
      6'h0F: begin k = K_I; ctl = 4'b1000; sb = 3'b101; end
      6'h23: k = K_LW;
      6'h2B: k = K_SW;
      6'h04: k = K_BEQ;
      6'h05: k = K_BNE;
      6'h02: k = K_J;
      default: k = K_ILL;
    endcase
  endfunction

  // memory phase: w idle cycles then ready; 1 if it completed
  function automatic bit mem_phase(logic [31:0] ins,
                                   int kind, int w);
    out_t o;
    bit r;
    for (int k = 0; k <= w && k <= WMAX; k++) begin
      r = (k == w);
      o = '0;
      o.mem_read  = (kind != 2);
      o.mem_write = (kind == 2);
      o.i_or_d    = (kind != 0);
      if (kind == 0) begin
        o.alu_src_b = 3'b001;
        o.alu_ctl   = 4'b0010;
        o.ir_write  = r;
        o.pc_write  = r;
      end
      o.bus_err = !r && (k == WMAX);
      put(1'b0, ins, r, rb(), o);
    end
    return (w <= WMAX);
  endfunction

  function automatic void gen(logic [31:0] ins, int wf,
                              int wm, bit bc);
    int k;
    logic [3:0] ctl;
    logic [2:0] sb;
    out_t o;
    bit done;
    classify(ins, k, ctl, sb);
    done = mem_phase(ins, 0, wf);
    while (!done)
      done = mem_phase(ins, 0, $urandom_range(0, 3));
    o = '0;
    o.alu_src_b = 3'b011;
    o.alu_ctl   = 4'b0010;
    o.illegal   = (k == K_ILL);
    put(1'b0, ins, rb(), rb(), o);
    case (k)
      K_R, K_I: begin
        o = '0;
        o.alu_src_a = 1'b1;
        o.alu_ctl   = ctl;
        o.alu_src_b = sb;
        put(1'b0, ins, rb(), rb(), o);
        o = '0;
        o.reg_write = 1'b1;
        o.reg_dst   = (k == K_R);
        put(1'b0, ins, rb(), rb(), o);
      end
      K_LW, K_SW: begin
        o = '0;
        o.alu_src_a = 1'b1;
        o.alu_src_b = 3'b010;
        o.alu_ctl   = 4'b0010;
        put(1'b0, ins, rb(), rb(), o);
        done = mem_phase(ins, (k == K_LW) ? 1 : 2, wm);
        if (done && k == K_LW) begin
          o = '0;
          o.reg_write  = 1'b1;
          o.mem_to_reg = 1'b1;
          put(1'b0, ins, rb(), rb(), o);
        end
      end
      K_BEQ, K_BNE: begin
        o = '0;
        o.alu_src_a = 1'b1;
        o.alu_ctl   = (k == K_BNE) ? 4'b1110 : 4'b0110;
        o.pc_source = 2'b01;
        o.pc_write  = bc;
        put(1'b0, ins, rb(), bc, o);
      end
      K_J: begin
        o = '0;
        o.pc_source = 2'b10;
        o.pc_write  = 1'b1;
        put(1'b0, ins, rb(), rb(), o);
      end
      default: ;
    endcase
  endfunction

  // instruction cut short by reset at a random cycle
  function automatic void gen_abort(logic [31:0] ins);
    int base, n, cut;
    base = exp_q.size();
    gen(ins, $urandom_range(0, 2), $urandom_range(0, 2), rb());
    n = exp_q.size() - base;
    cut = $urandom_range(0, n - 1);
    while (exp_q.size() > base + cut) begin
      void'(exp_q.pop_back());
      void'(drv_q.pop_back());
    end
    push_reset($urandom_range(1, 2));
  endfunction

  function automatic bit in_list(logic [5:0] v, bit fnl);
    logic [5:0] fns [9] = '{6'h20, 6'h21, 6'h22, 6'h24,
                            6'h25, 6'h26, 6'h2A, 6'h00, 6'h02};
    logic [5:0] ops [13] = '{6'h00, 6'h08, 6'h09, 6'h0A,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
                             6'h2B, 6'h04, 6'h05, 6'h02};
    if (fnl) begin
      foreach (fns[i]) if (fns[i] == v) return 1'b1;
    end else begin
      foreach (ops[i]) if (ops[i] == v) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fns [9] = '{6'h20, 6'h21, 6'h22, 6'h24,
                            6'h25, 6'h26, 6'h2A, 6'h00, 6'h02};
    logic [5:0] ops [12] = '{6'h08, 6'h09, 6'h0A, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
                             6'h04, 6'h05, 6'h02};
    logic [31:0] b;
    logic [5:0] v;
    int r;
    b = $urandom;
    r = $urandom_range(0, 15);
    if (r < 3) begin
      v = fns[$urandom_range(0, 8)];
      return {6'h00, b[25:6], v};
    end else if (r == 3) begin
      v = 6'($urandom);
      while (in_list(v, 1'b1)) v = 6'($urandom);
      return {6'h00, b[25:6], v};
    end else if (r == 4) begin
      v = 6'($urandom);
      while (in_list(v, 1'b0)) v = 6'($urandom);
      return {v, b[25:0]};
    end
    v = ops[$urandom_range(0, 11)];
    return {v, b[25:0]};
  endfunction

  function automatic int rnd_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 3);
    return $urandom_range(14, 17);
  endfunction

  function automatic void build();
    push_reset(3);
    gen(32'h00221820, 0, 0, 1'b0);
    gen(32'h00221822, 0, 0, 1'b0);
    gen(32'h10220003, 0, 0, 1'b1);
    gen(32'h10220003, 0, 0, 1'b0);
    gen(32'h14220003, 0, 0, 1'b1);
    gen(32'h14220003, 1, 0, 1'b0);
    gen(32'h8C220004, 0, 3, 1'b0);
    gen(32'hAC220004, 2, 1, 1'b0);
    gen(32'h00221820, 16, 0, 1'b0);
    gen(32'h08000010, 15, 0, 1'b0);
    gen(32'h8C220004, 0, 15, 1'b0);
    gen(32'h8C220004, 0, 16, 1'b0);
    gen(32'hAC220004, 0, 16, 1'b0);
    gen(32'h3C011234, 0, 0, 1'b0);
    gen(32'h00021080, 0, 0, 1'b0);
    gen(32'hFC000000, 0, 0, 1'b0);
    gen(32'h00221801, 0, 0, 1'b0);
    gen_abort(32'h8C220004);
    for (int i = 0; i < 200; i++) begin
      if (i % 25 == 24) gen_abort(rnd_instr());
      else gen(rnd_instr(), rnd_wait(), rnd_wait(), rb());
    end
  endfunction

  // monitor: one expected record per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cyc%0d outputs got %h want %h",
                 cyc, act, e);
      end
      cyc++;
    end
  end

  // driver: one input record per cycle, just after the edge
  initial begin
    in_t d;
    build();
    while (drv_q.size() > 0) begin
      d = drv_q.pop_front();
      @(posedge clk);
      #1;
      rst_n    = !d.rst;
      instr    = d.ins;
      rdy_d    = d.rdy;
      alu_cond = d.cond;
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain left %0d want 0", exp_q.size());
      $fatal(1, "scoreboard not drained");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
